// File: rtl/banco_pkg.sv
// banco_pkg: shared widths and FSM state type for the register-file write arbiter.
package banco_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned NUM_REGS   = 1 << DEF_ADDR_W;

   typedef enum logic [1:0] {
      OCIOSO,
      ESCRITA,
      LIMPEZA
   } estado_arb_t;

endpackage

// File: rtl/arbitro_escrita_banco_seletor_rr.sv
// seletor_rr: combinational rotating-priority selector; first asserted request at
// index >= ptr (wrapping) wins. Tie ptr to 0 for fixed lowest-index priority.
module seletor_rr
   import banco_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic        achou;
   int unsigned cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      achou   = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         // inner loop keeps every select index a loop constant
         for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!achou && (cand == j) && req[j]) begin
               achou   = 1'b1;
               gnt[j]  = 1'b1;
               gnt_idx = IDX_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco: sole driver of the register-file write port; arbitrates
// writeback requesters and runs a zeroing sweep. ARB_RR_EN selects round-robin.
module arbitro_escrita_banco
   import banco_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      clear_start,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      clear_done
);

   localparam int unsigned IDX_W = 3;

   estado_arb_t       estado_q, estado_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic              clear_done_q, clear_done_d;

   logic [N_REQ-1:0]  gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic [IDX_W-1:0]  ptr_sel;
   logic              libera;

   seletor_rr #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_seletor (
      .req     (req_valid),
      .ptr     (ptr_sel),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

`ifdef ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   assign ptr_sel = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (|req_ready) begin
         ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign ptr_sel = '0;
`endif

   assign libera    = (estado_q != LIMPEZA) && !clear_start && !reset;
   assign req_ready = libera ? gnt : '0;

   always_comb begin
      estado_d     = OCIOSO;
      cnt_d        = '0;
      wr_en_d      = 1'b0;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      grant_id_d   = '0;
      clear_done_d = 1'b0;
      case (estado_q)
         LIMPEZA: begin
            if (cnt_q == '1) begin
               clear_done_d = 1'b1;
            end else begin
               estado_d  = LIMPEZA;
               cnt_d     = cnt_q + ADDR_W'(1);
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q + ADDR_W'(1);
            end
         end
         default: begin
            // sweep starts with counter 0 already on wr_* in the first LIMPEZA cycle
            if (clear_start) begin
               estado_d = LIMPEZA;
               wr_en_d  = 1'b1;
            end else if (|req_ready) begin
               estado_d   = ESCRITA;
               wr_en_d    = 1'b1;
               grant_id_d = gnt_idx;
               for (int unsigned j = 0; j < N_REQ; j++) begin
                  if (gnt[j]) begin
                     wr_addr_d = req_addr[j*ADDR_W +: ADDR_W];
                     wr_data_d = req_data[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q     <= OCIOSO;
         cnt_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         grant_id_q   <= '0;
         clear_done_q <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         cnt_q        <= cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         grant_id_q   <= grant_id_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign grant_id   = grant_id_q;
   assign busy       = (estado_q == LIMPEZA);
   assign clear_done = clear_done_q;

endmodule

// File: doc/arbitro_escrita_banco.md
# arbitro_escrita_banco

Sequencing controller for the 16×16-bit register file's single write port (write enable, write address, write data). It arbitrates up to N_REQ writeback sources with a valid/ready handshake and registers the winning write into a one-cycle write pulse. It also runs a hardware clear sequence that zeroes all registers one per cycle. It sits between the pipeline writeback sources and the register file, and it is the only driver of the file's write port.

## Interface
- N_REQ, 4, number of write requesters (2..8)
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (2^ADDR_W registers)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  N_REQ  requester i has a pending write
- req_addr  in  N_REQ*ADDR_W  packed target addresses; slice i = [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed write data; slice i = [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot or zero; combinational grant
- clear_start  in  1  pulse that requests a full register clear
- wr_en  out  1  register-file write enable, registered
- wr_addr  out  ADDR_W  register-file write address, registered
- wr_data  out  DATA_W  register-file write data, registered
- grant_id  out  3  index of the requester whose write is on wr_* this cycle, registered
- busy  out  1  high while in LIMPEZA
- clear_done  out  1  one-cycle pulse after the last clear write

## Operation
- States:
  - OCIOSO: no write was accepted last cycle.
  - ESCRITA: a write was accepted last cycle and is now on wr_*.
  - LIMPEZA: clear sweep in progress.
- Transfer rule: requester i transfers when req_valid[i] and req_ready[i] are both high in the same cycle. The captured addr/data drive wr_* on the next cycle with wr_en=1.
- req_ready is asserted for at most one requester, and only when all of these hold:
  - state is not LIMPEZA
  - clear_start=0
  - reset=0
  - that requester wins arbitration among the asserted req_valid bits
- OCIOSO/ESCRITA → ESCRITA if a transfer occurs, else → OCIOSO. Accepting a new write every cycle is allowed, so sustained throughput is 1 write per clock.
- clear_start=1 in OCIOSO/ESCRITA:
  - No grant is issued that cycle.
  - The next state is LIMPEZA with the clear counter at 0.
  - A write already registered on wr_* still completes in that cycle.
- LIMPEZA:
  - wr_en=1, wr_addr=counter, wr_data=0, busy=1.
  - The counter increments every cycle.
  - After the cycle with counter=2^ADDR_W-1, the block goes to OCIOSO and pulses clear_done for one cycle.
  - clear_start is ignored while in LIMPEZA.
- grant_id holds the granted index during ESCRITA and reads 0 in OCIOSO and LIMPEZA.
- Address collisions between requesters are not detected. Same-address writes on consecutive cycles are serialized in grant order, so the later grant wins.
- A requester may drop req_valid only after its transfer. req_addr and req_data must be stable while req_valid is high and req_ready is low.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0, busy=0, clear_done=0
  - req_ready=0 while reset is high
  - state=OCIOSO, round-robin pointer=0, clear counter=0
- Latency: transfer at edge k → wr_en=1 during cycle k+1. The register file commits the write at edge k+1.
- Clear sequence: clear_start sampled at edge k → wr_en=1 on cycles k+1..k+2^ADDR_W → clear_done=1 on cycle k+2^ADDR_W+1, with busy=0 and grants allowed again in that cycle.
- Reset asserted mid-clear: the sweep aborts immediately, and no clear_done pulse is produced.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - The search starts at pointer p; the first valid requester at index ≥ p (wrapping) wins.
  - After a grant to i, p becomes (i+1) mod N_REQ.
  - p is unchanged when no grant is made.
- ARB_RR_EN undefined: fixed priority; the lowest asserted index wins and the pointer logic is not built.

## Structure
- Shared package banco_pkg holds:
  - DATA_W and ADDR_W defaults
  - NUM_REGS = 2^ADDR_W
  - typedef estado_arb_t {OCIOSO, ESCRITA, LIMPEZA}
- One sub-module, seletor_rr, is natural.
  - Inputs: request vector and pointer. Outputs: one-hot grant and granted index.
  - It is combinational, and fixed priority is obtained with pointer tied to 0.
- The top level holds the FSM, output registers, clear counter and pointer.

## Test plan
- Single write: req_valid[2]=1, addr=5, data=16'hBEEF → req_ready[2]=1 that cycle; next cycle wr_en=1, wr_addr=5, wr_data=BEEF, grant_id=2; then wr_en=0.
- Contention with ARB_RR_EN: all four requesters valid for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles. Without the macro → eight grants to requester 0.
- Back-to-back: requester 1 writes addr 3 with 16'h0001 then 16'h0002 on consecutive cycles → wr_en high two cycles and register 3 ends at 16'h0002.
- Clear: clear_start pulse with requester 0 valid → req_ready=0 for 17 cycles; wr_addr steps 0..15 with wr_data=0; clear_done pulses once; requester 0 is then granted in the clear_done cycle.
- Reset mid-clear: reset asserted at wr_addr=7 → all outputs 0 immediately; after release the state is OCIOSO, there is no clear_done, and the pointer is 0.
